// File: rtl/dict_stream_ctrl_if.sv
// Handshake bundle for the dictionary stream controller: index input, chunk output and codebook config.
// The master drives stimulus and config; the slave is the controller.
interface dict_stream_ctrl_if #(
    parameter int unsigned CHUNK_SIZE    = 4,
    parameter int unsigned CODEBOOK_SIZE = 8,
    parameter int unsigned IDX_PER_WORD  = 4,
    parameter int unsigned OUT_CHUNKS    = 8
);
    localparam int unsigned INDEX_BITS = $clog2(CODEBOOK_SIZE);
    localparam int unsigned CW         = $clog2(IDX_PER_WORD + 1);
    localparam int unsigned FW         = $clog2(OUT_CHUNKS + 1);
    localparam int unsigned WW         = IDX_PER_WORD * INDEX_BITS;
    localparam int unsigned OW         = OUT_CHUNKS * CHUNK_SIZE;

    logic                  in_valid;
    logic                  in_ready;
    logic [WW-1:0]         in_data;
    logic [CW-1:0]         in_count;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [OW-1:0]         out_data;
    logic [FW-1:0]         out_nchunks;
    logic                  out_last;
    logic                  cfg_we;
    logic [INDEX_BITS-1:0] cfg_addr;
    logic [CHUNK_SIZE-1:0] cfg_data;
    logic                  cfg_ready;
    logic                  busy;

    modport master (
        output in_valid, in_data, in_count, in_last, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, out_nchunks, out_last, cfg_ready, busy
    );

    modport slave (
        input  in_valid, in_data, in_count, in_last, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, out_nchunks, out_last, cfg_ready, busy
    );
endinterface

// File: rtl/dict_stream_ctrl.sv
// Unpacks packed codebook indices one per cycle, looks each up in a programmable codebook,
// and assembles the chunks into wide output beats with partial flush and last marking.
module dict_stream_ctrl #(
    parameter int unsigned CHUNK_SIZE    = 4,
    parameter int unsigned CODEBOOK_SIZE = 8,
    parameter int unsigned IDX_PER_WORD  = 4,
    parameter int unsigned OUT_CHUNKS    = 8
) (
    input logic               clk,
    input logic               rst,
    dict_stream_ctrl_if.slave bus
);
    localparam int unsigned INDEX_BITS = $clog2(CODEBOOK_SIZE);
    localparam int unsigned CW         = $clog2(IDX_PER_WORD + 1);
    localparam int unsigned FW         = $clog2(OUT_CHUNKS + 1);
    localparam int unsigned WW         = IDX_PER_WORD * INDEX_BITS;
    localparam int unsigned OW         = OUT_CHUNKS * CHUNK_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_EMIT} state_t;

    state_t                r_state,   w_state_n;
    logic [WW-1:0]         r_word,    w_word_n;
    logic [CW-1:0]         r_count,   w_count_n;
    logic                  r_last,    w_last_n;
    logic [CW-1:0]         r_k,       w_k_n;
    logic [FW-1:0]         r_fill,    w_fill_n;
    logic [OW-1:0]         r_chunks,  w_chunks_n;
    logic                  r_out_valid,   w_out_valid_n;
    logic [OW-1:0]         r_out_data,    w_out_data_n;
    logic [FW-1:0]         r_out_nchunks, w_out_nchunks_n;
    logic                  r_out_last,    w_out_last_n;
    logic                  r_cfg_ready,   w_cfg_ready_n;
    logic                  r_busy,        w_busy_n;
    logic [CHUNK_SIZE-1:0] r_cb [CODEBOOK_SIZE];

    logic                  w_in_ready;
    logic                  w_cb_we;
    logic [INDEX_BITS-1:0] w_idx;
    logic [CHUNK_SIZE-1:0] w_entry;

    function automatic logic [CHUNK_SIZE-1:0] cb_default(input int unsigned i);
        case (i)
            0:       return CHUNK_SIZE'(4'b0000);
            1:       return CHUNK_SIZE'(4'b0010);
            2:       return CHUNK_SIZE'(4'b1001);
            3:       return CHUNK_SIZE'(4'b1011);
            4:       return CHUNK_SIZE'(4'b1111);
            5:       return CHUNK_SIZE'(4'b1000);
            6:       return CHUNK_SIZE'(4'b1100);
            7:       return CHUNK_SIZE'(4'b0111);
            default: return '0;
        endcase
    endfunction

    // r_cfg_ready doubles as "in IDLE and out of reset", so input acceptance keys off it
    assign w_in_ready = r_cfg_ready && !bus.cfg_we;

    always_comb begin
        w_state_n       = r_state;
        w_word_n        = r_word;
        w_count_n       = r_count;
        w_last_n        = r_last;
        w_k_n           = r_k;
        w_fill_n        = r_fill;
        w_chunks_n      = r_chunks;
        w_out_valid_n   = r_out_valid;
        w_out_data_n    = r_out_data;
        w_out_nchunks_n = r_out_nchunks;
        w_out_last_n    = r_out_last;
        w_cb_we         = 1'b0;
        w_idx           = '0;
        w_entry         = '0;

        case (r_state)
            S_IDLE: begin
                w_cb_we = r_cfg_ready && bus.cfg_we;
                if (w_in_ready && bus.in_valid) begin
                    w_word_n  = bus.in_data;
                    w_count_n = bus.in_count;
                    w_last_n  = bus.in_last;
                    w_k_n     = '0;
                    w_state_n = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (r_k < r_count) begin
                    for (int unsigned i = 0; i < IDX_PER_WORD; i++)
                        if (CW'(i) == r_k) w_idx = r_word[i*INDEX_BITS +: INDEX_BITS];
                    w_entry = r_cb[w_idx];
                    for (int unsigned j = 0; j < OUT_CHUNKS; j++)
                        if (FW'(j) == r_fill) w_chunks_n[j*CHUNK_SIZE +: CHUNK_SIZE] = w_entry;
                    w_fill_n = r_fill + FW'(1);
                    w_k_n    = r_k + CW'(1);
                end
                // Full beat or end of a last word both emit; the beat captures post-write state
                if (w_fill_n == FW'(OUT_CHUNKS) || (w_k_n == r_count && r_last)) begin
                    w_state_n       = S_EMIT;
                    w_out_valid_n   = 1'b1;
                    w_out_data_n    = w_chunks_n;
                    w_out_nchunks_n = w_fill_n;
                    w_out_last_n    = r_last && (w_k_n == r_count);
                end else if (w_k_n == r_count) begin
                    w_state_n = S_IDLE;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    w_fill_n        = '0;
                    w_chunks_n      = '0;
                    w_out_valid_n   = 1'b0;
                    w_out_data_n    = '0;
                    w_out_nchunks_n = '0;
                    w_out_last_n    = 1'b0;
                    w_state_n       = (r_k != r_count) ? S_UNPACK : S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        w_cfg_ready_n = (w_state_n == S_IDLE);
        w_busy_n      = (w_state_n != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_word        <= '0;
            r_count       <= '0;
            r_last        <= 1'b0;
            r_k           <= '0;
            r_fill        <= '0;
            r_chunks      <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_nchunks <= '0;
            r_out_last    <= 1'b0;
            r_cfg_ready   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_word        <= w_word_n;
            r_count       <= w_count_n;
            r_last        <= w_last_n;
            r_k           <= w_k_n;
            r_fill        <= w_fill_n;
            r_chunks      <= w_chunks_n;
            r_out_valid   <= w_out_valid_n;
            r_out_data    <= w_out_data_n;
            r_out_nchunks <= w_out_nchunks_n;
            r_out_last    <= w_out_last_n;
            r_cfg_ready   <= w_cfg_ready_n;
            r_busy        <= w_busy_n;
        end
    end

    // Codebook storage; reset restores the default table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CODEBOOK_SIZE; i++) r_cb[i] <= cb_default(i);
        end else if (w_cb_we) begin
            r_cb[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_nchunks = r_out_nchunks;
    assign bus.out_last    = r_out_last;
    assign bus.cfg_ready   = r_cfg_ready;
    assign bus.busy        = r_busy;
endmodule

// File: doc/dict_stream_ctrl.md
Name: dict_stream_ctrl

Overview:
Streaming controller that sequences the dictionary codebook lookup datapath. It accepts packed words of codebook indices over a valid/ready handshake and unpacks them one index per cycle. Each index is looked up in an internal runtime-programmable codebook, and the resulting chunks are assembled into wide output words with valid/ready handshake, partial-word flush and last marking. It sits between the compressed-index stream source and the downstream bit-stream consumer, and owns codebook configuration.

Parameters:
CHUNK_SIZE, 4, bits per decompressed chunk
CODEBOOK_SIZE, 8, codebook entries
INDEX_BITS, $clog2(CODEBOOK_SIZE), bits per index
IDX_PER_WORD, 4, indices per input word
OUT_CHUNKS, 8, chunks per output word

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input word valid
in_ready  out  1  controller accepts input word
in_data  in  IDX_PER_WORD*INDEX_BITS  packed indices, index k at bits [k*INDEX_BITS +: INDEX_BITS]
in_count  in  $clog2(IDX_PER_WORD+1)  number of valid indices, 0..IDX_PER_WORD, lowest first
in_last  in  1  final word of the stream
out_valid  out  1  output word valid
out_ready  in  1  consumer accepts output
out_data  out  OUT_CHUNKS*CHUNK_SIZE  chunk j at bits [j*CHUNK_SIZE +: CHUNK_SIZE], unfilled chunks zero
out_nchunks  out  $clog2(OUT_CHUNKS+1)  valid chunks in out_data
out_last  out  1  final output word of the stream
cfg_we  in  1  codebook write strobe
cfg_addr  in  INDEX_BITS  codebook entry to write
cfg_data  in  CHUNK_SIZE  new entry value
cfg_ready  out  1  high when a write is accepted this cycle
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock domain; clk, with asynchronous active-high rst.
- Reset values: in_ready=0, out_valid=0, out_data=0, out_nchunks=0, out_last=0, cfg_ready=0, busy=0. Fill counter is 0 and state is IDLE.
- Codebook reset contents: 0000, 0010, 1001, 1011, 1111, 1000, 1100, 0111 for entries 0..7.
- Reset mid-operation discards the latched word and any partial output, and reverts the codebook to the defaults.
- FSM states: IDLE, UNPACK, EMIT.
- IDLE:
  - cfg_ready=1 and in_ready=!cfg_we.
  - cfg_we writes the entry at the next edge. A config write has priority over input acceptance in the same cycle.
  - On an in_valid&&in_ready edge, the controller latches in_data, in_count and in_last, sets k=0, and goes to UNPACK.
- UNPACK:
  - Each cycle with k<count: chunk[fill] <= codebook[idx k], then fill++ and k++.
  - If fill reaches OUT_CHUNKS, go to EMIT. Remaining indices resume after that emit.
  - If k==count with no remaining indices:
    - last set: go to EMIT. This also applies when fill==0, producing an empty beat with out_nchunks=0 and out_last=1.
    - last clear and fill>0: return to IDLE and keep the partial fill for the next word.
    - last clear and fill==0: return to IDLE.
  - in_count=0 latches no indices; the word still processes its in_last flag.
- EMIT:
  - out_valid=1. out_data, out_nchunks and out_last are held stable until out_ready.
  - out_last=1 only if the latched word has last set and no indices remain after this beat.
  - On out_ready: clear fill and the chunk register to zero.
    - Indices remain: go to UNPACK.
    - Otherwise: go to IDLE.
- Handshakes and latency:
  - in_ready=0 and cfg_ready=0 outside IDLE.
  - Latency from input accept to out_valid: count+1 cycles when the word completes or flushes the output.
- Codebook reads always use the current contents. Writes are impossible mid-stream because cfg_ready=0 outside IDLE.
- Index values are unsigned and always in range, since CODEBOOK_SIZE=2^INDEX_BITS by default.

Test Plan:
- Default table:
  - Stimulus: two words, in_data=12'h3E2 (indices 2,4,7,1), count=4; second word in_last=1.
  - Response: one beat out_data=32'h27F927F9, out_nchunks=8, out_last=1. First word accepted at cycle T, out_valid at T+4+1+4+1 (with no gaps).
- Partial flush:
  - Stimulus: in_data=12'h1A8 (indices 0,5,6), count=3, last=1.
  - Response: out_data=32'h00000C80, out_nchunks=3, out_last=1.
- Configuration:
  - Stimulus: in IDLE, cfg_we=1, addr=3, data=4'b0101 with in_valid=1 in the same cycle. Next, a word with index 3, count=1, last=1.
  - Response: cfg_ready=1 and in_ready=0 in the write cycle; out_data=32'h5, out_nchunks=1.
- Backpressure and overflow:
  - Stimulus: three words of count=4 (12 chunks), last on the third; out_ready low for 5 cycles at the first EMIT.
  - Response: out_data stable, in_ready=0 and busy=1 throughout. Then beat 1 has nchunks=8 and last=0; beat 2 has nchunks=4 and last=1.
- Empty last:
  - Stimulus: count=0, last=1 from IDLE.
  - Response: one beat out_nchunks=0, out_data=0, out_last=1.
- Reset mid-operation:
  - Stimulus: write entry 3 := 0101, then pulse rst during UNPACK.
  - Response: all outputs 0 and busy=0 immediately. A subsequent index-3 word yields chunk 1011.
